// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single-ported data memory.
// One transaction in flight; round-robin on ties; fixed MEM_LAT read latency.
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,

  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_addr,
  input  logic        ls_write,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wstrb,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rdata,

  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic       GNT_IF = 1'b0;
  localparam logic       GNT_LS = 1'b1;
  localparam logic [2:0] LAT    = 3'(MEM_LAT);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        last_grant;
  logic        grant;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        write_q;
  logic        if_win, ls_win;
  logic        accept;
  logic        capture;

  // Fetch wins when alone, or on a tie when load/store was granted last.
  assign if_win  = if_req_valid && (!ls_req_valid || last_grant == GNT_LS);
  assign ls_win  = ls_req_valid && !if_win;
  assign capture = (state == WAIT) && (cnt == 3'd1) && !write_q;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign mem_write = mem_en && write_q;

  always_comb begin
    state_nxt    = state;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    if_rsp_valid = 1'b0;
    ls_rsp_valid = 1'b0;
    mem_en       = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if_req_ready = if_win;
          ls_req_ready = ls_win;
          if (if_win || ls_win) begin
            accept    = 1'b1;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        mem_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 3'd1) state_nxt = RESP;
      end
      RESP: begin
        if_rsp_valid = (grant == GNT_IF);
        ls_rsp_valid = (grant == GNT_LS);
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last_grant <= GNT_LS;
      grant      <= GNT_IF;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      write_q    <= 1'b0;
      if_rdata   <= 32'd0;
      ls_rdata   <= 32'd0;
    end else begin
      state <= state_nxt;

      if (state == ACCESS)    cnt <= LAT;
      else if (state == WAIT) cnt <= cnt - 3'd1;
      else                    cnt <= 3'd0;

      if (accept) begin
        grant      <= ls_win;
        last_grant <= ls_win;
        addr_q     <= ls_win ? ls_addr : if_addr;
        write_q    <= ls_win && ls_write;
        wdata_q    <= ls_win ? ls_wdata : 32'd0;
        wstrb_q    <= ls_win ? ls_wstrb : 4'd0;
      end

      // Writes leave both read-data registers untouched.
      if (capture) begin
        if (grant == GNT_IF) if_rdata <= mem_rdata;
        else                 ls_rdata <= mem_rdata;
      end
    end
  end

endmodule
